// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz raster timing constants shared by the sync generator and
// the pixel-generation logic of the VGA design.
package vga_timing_pkg;

   // Horizontal timing, in pixel clocks.
   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;

   // Vertical timing, in lines.
   localparam int V_DISPLAY = 480;
   localparam int V_BOTTOM  = 10;
   localparam int V_SYNC    = 2;
   localparam int V_TOP     = 33;

   // Derived counter limits and sync windows.
   localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;  // 799
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;                        // 656
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;                  // 751
   localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;  // 524
   localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;                       // 490
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;                  // 491

endpackage

// File: rtl/hvsync_generator.sv
// Free-running VGA raster counters with registered active-low syncs and a
// combinational active-video flag.
module hvsync_generator #(
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_BOTTOM  = vga_timing_pkg::V_BOTTOM,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_TOP     = vga_timing_pkg::V_TOP
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos
);

   localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
   localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
   localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
   localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
   localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);

   // Pixel/line counters and sync registers; syncs are judged on the pre-edge
   // counter values, so they trail the counters by exactly one clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos  <= '0;
         vpos  <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         // NOTE: non-blocking updates keep every register reading the same
         // pre-edge hpos/vpos, which is what gives the one-cycle sync delay.
         hsync <= !((hpos >= H_SYNC_START) && (hpos <= H_SYNC_END));
         vsync <= !((vpos >= V_SYNC_START) && (vpos <= V_SYNC_END));
         if (hpos == H_MAX) begin
            hpos <= '0;
            vpos <= (vpos == V_MAX) ? '0 : vpos + 10'd1;
         end else begin
            hpos <= hpos + 10'd1;
         end
      end
   end

   // Active video straight from the counters, no extra latency.
   assign display_on = (hpos < H_VISIBLE) && (vpos < V_VISIBLE);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: a default 640x480 instance for reset and horizontal timing,
// and a shrunken-raster instance for vertical, frame-wrap and mid-frame reset.
module tb_hvsync_generator;

   logic       clk;
   logic       reset;
   logic       reset_s;

   logic       hsync, vsync, display_on;
   logic [9:0] hpos, vpos;
   logic       hsync_s, vsync_s, display_on_s;
   logic [9:0] hpos_s, vpos_s;

   int errors = 0;
   int checks = 0;

   hvsync_generator dut (
      .clk        (clk),
      .reset      (reset),
      .hsync      (hsync),
      .vsync      (vsync),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos)
   );

   // Small raster: 16 clocks/line (8 visible, sync hpos 10..12),
   // 12 lines/frame (6 visible, sync vpos 8..9), 192 clocks/frame.
   hvsync_generator #(
      .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
      .V_DISPLAY (6), .V_BOTTOM (2), .V_SYNC (2), .V_TOP (2)
   ) dut_s (
      .clk        (clk),
      .reset      (reset_s),
      .hsync      (hsync_s),
      .vsync      (vsync_s),
      .display_on (display_on_s),
      .hpos       (hpos_s),
      .vpos       (vpos_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int hs_low, first_low_h, last_low_h, off_cnt, first_off_h;
      int pos_bad, hs_bad;
      int max_h, max_v, vs_low, fv_v, fv_h, lv_v, lv_h, disp_bad, step_bad, hs_low_s;
      int prev_h, wait_n;
      bit seen;

      reset   = 1'b1;
      reset_s = 1'b1;
      repeat (2) @(negedge clk);

      // Reset values.
      check("rst_hpos", hpos, 0);
      check("rst_vpos", vpos, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_disp", display_on, 1);

      // Release, then one edge gives hpos=1.
      reset = 1'b0;
      @(negedge clk);
      check("rel_hpos", hpos, 1);
      check("rel_vpos", vpos, 0);

      // Two full lines on the default raster. Sample n = posedges since release.
      hs_low = 0; first_low_h = -1; last_low_h = -1; off_cnt = 0; first_off_h = -1;
      pos_bad = 0; hs_bad = 0;
      for (int n = 1; n <= 1600; n++) begin
         if (n > 1) @(negedge clk);
         if (hpos !== 10'(n % 800) || vpos !== 10'(n / 800)) pos_bad++;
         if (hsync === 1'b0) begin
            hs_low++;
            if (first_low_h < 0) first_low_h = hpos;
            if (n < 800) last_low_h = hpos;
         end
         if (hsync !== ((n % 800) >= 657 && (n % 800) <= 752 ? 1'b0 : 1'b1)) hs_bad++;
         if (display_on === 1'b0) begin
            off_cnt++;
            if (first_off_h < 0) first_off_h = hpos;
         end
         if (n == 800) begin
            check("line_wrap_hpos", hpos, 0);
            check("line_wrap_vpos", vpos, 1);
         end
      end
      check("h_pos_track", pos_bad, 0);
      check("hsync_first_low", first_low_h, 657);
      check("hsync_last_low", last_low_h, 752);
      check("hsync_low_2lines", hs_low, 192);
      check("hsync_pattern", hs_bad, 0);
      check("disp_off_2lines", off_cnt, 320);
      check("disp_first_off", first_off_h, 640);

      // Mid-line reset on the default raster, asserted between clock edges.
      repeat (400) @(negedge clk);
      check("pre_rst_hpos", hpos, 400);
      check("pre_rst_vpos", vpos, 2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_hpos", hpos, 0);
      check("async_rst_vpos", vpos, 0);
      check("async_rst_disp", display_on, 1);
      repeat (3) @(negedge clk);
      check("held_rst_hpos", hpos, 0);
      check("held_rst_hsync", hsync, 1);
      reset = 1'b0;
      @(negedge clk);
      check("restart_hpos", hpos, 1);
      check("restart_vpos", vpos, 0);

      // One full frame on the small raster.
      reset_s = 1'b0;
      max_h = 0; max_v = 0; vs_low = 0; fv_v = -1; fv_h = -1; lv_v = -1; lv_h = -1;
      disp_bad = 0; step_bad = 0; hs_low_s = 0; prev_h = 0;
      for (int n = 1; n <= 192; n++) begin
         @(negedge clk);
         if (int'(hpos_s) > max_h) max_h = hpos_s;
         if (int'(vpos_s) > max_v) max_v = vpos_s;
         if (!((int'(hpos_s) == prev_h + 1) || (prev_h == 15 && hpos_s == 10'd0))) step_bad++;
         prev_h = hpos_s;
         if (vsync_s === 1'b0) begin
            vs_low++;
            if (fv_v < 0) begin fv_v = vpos_s; fv_h = hpos_s; end
            lv_v = vpos_s; lv_h = hpos_s;
         end
         if (hsync_s === 1'b0) hs_low_s++;
         if (display_on_s !== ((n % 16) < 8 && ((n / 16) % 12) < 6)) disp_bad++;
      end
      check("frame_wrap_hpos", hpos_s, 0);
      check("frame_wrap_vpos", vpos_s, 0);
      check("frame_max_hpos", max_h, 15);
      check("frame_max_vpos", max_v, 11);
      check("frame_h_steps", step_bad, 0);
      check("vsync_first_v", fv_v, 8);
      check("vsync_first_h", fv_h, 1);
      check("vsync_last_v", lv_v, 10);
      check("vsync_last_h", lv_h, 0);
      check("vsync_low_cnt", vs_low, 32);
      check("hsync_low_frame", hs_low_s, 36);
      check("disp_frame", disp_bad, 0);

      // Mid-frame reset on the small raster, then time to the next vsync fall.
      repeat (70) @(negedge clk);
      check("s_pre_rst_hpos", hpos_s, 6);
      check("s_pre_rst_vpos", vpos_s, 4);
      #2 reset_s = 1'b1;
      #1;
      check("s_async_rst_hpos", hpos_s, 0);
      check("s_async_rst_vpos", vpos_s, 0);
      repeat (3) @(negedge clk);
      reset_s = 1'b0;
      @(negedge clk);
      check("s_restart_hpos", hpos_s, 1);
      check("s_restart_vpos", vpos_s, 0);
      wait_n = 0;
      seen = 1'b0;
      while (!seen && wait_n < 1000) begin
         @(negedge clk);
         wait_n++;
         if (vsync_s === 1'b0) seen = 1'b1;
      end
      check("s_vsync_seen", int'(seen), 1);
      check("s_vsync_delay", wait_n, 8 * 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
